led_pattern_sequencer: RTL
==========================

// Module: led_pattern_sequencer
// PURPOSE
//  Sequences a bank of N_LED LEDs through a programmable table of up to N_STEP
//  steps; each step holds an LED pattern and a duration in base ticks.
//  A built-in prescaler generates the base tick (default 0.5 s at 125 MHz).
//  Sits between board-level LED pins and a host/CPU config port.
// PARAMETERS
//  N_LED     4         number of LED outputs
//  N_STEP    8         table depth (power of two, >=2)
//  DUR_W     8         width of per-step duration field (ticks)
//  TICK_DIV  62500000  CLK cycles per base tick (>=2)
// PORTS
//  CLK          in   1                 system clock, rising edge
//  RST          in   1                 asynchronous reset, active-low
//  CFG_VALID    in   1                 table write request
//  CFG_READY    out  1                 table write accepted when VALID&READY
//  CFG_ADDR     in   log2(N_STEP)      table entry index
//  CFG_PATTERN  in   N_LED             LED pattern for entry
//  CFG_DUR      in   DUR_W             duration of entry in ticks (0 == 1)
//  CMD_START    in   1                 1-cycle pulse: begin sequence
//  CMD_STOP     in   1                 1-cycle pulse: abort, blank LEDs
//  LEN          in   log2(N_STEP)+1    active step count, sampled on START
//  LED          out  N_LED             registered LED drive
//  BUSY         out  1                 1 while in RUN
//  STEP_IDX     out  log2(N_STEP)      index of step currently shown
//  WRAP         out  1                 1-cycle pulse when idx wraps to 0
// BEHAVIOUR
//  Reset (RST=0, async): state IDLE; LED=0, BUSY=0, STEP_IDX=0, WRAP=0,
//   CFG_READY=1; all table entries {pattern=0,dur=0}; prescaler=0, dur_cnt=0.
//  States: IDLE, RUN. All outputs registered.
//  Table write: CFG_READY=1 only in IDLE; write commits on VALID&READY edge.
//   In RUN CFG_READY=0, writes not accepted, table unchanged.
//  IDLE->RUN: CMD_START=1 and 1<=LEN<=N_STEP. LEN=0 or LEN>N_STEP: ignored.
//   Same edge: len_q<=LEN, idx<=0, LED<=tab[0].pattern, dur_cnt<=max(tab[0].dur,1),
//   prescaler<=0, BUSY<=1. LED visible 1 cycle after START.
//  CMD_START in RUN: ignored (no restart, len_q unchanged).
//  CMD_STOP (any state): next edge -> IDLE, LED=0, BUSY=0, STEP_IDX=0, WRAP=0.
//   STOP and START in same cycle: STOP wins.
//  Prescaler: counts 0..TICK_DIV-1 only in RUN; tick=1 for the cycle it equals
//   TICK_DIV-1, then wraps to 0. Held at 0 in IDLE.
//  On tick in RUN: if dur_cnt>1, dur_cnt-1. Else advance: nidx = (idx==len_q-1)
//   ? 0 : idx+1; LED<=tab[nidx].pattern; dur_cnt<=max(tab[nidx].dur,1);
//   STEP_IDX<=nidx; WRAP<=1 for one cycle iff nidx==0 by wrap.
//  LEN=1: step 0 repeats; WRAP pulses every max(dur0,1)*TICK_DIV cycles.
//  Step k displayed for exactly max(dur_k,1)*TICK_DIV cycles (first step incl.).
//  Counter widths: prescaler $clog2(TICK_DIV); no overflow possible.
// STRUCTURE
//  Shared package/header led_pkg: state encoding (ST_IDLE, ST_RUN),
//   default TICK_DIV constant, step-entry field widths.
//  Sub-module led_tick_gen: prescaler with enable and sync clear, output tick.
//  Table as reg array (N_STEP x (N_LED+DUR_W)), async-read mux.
// TESTING (sim with TICK_DIV=4, N_LED=4, N_STEP=8, DUR_W=8)
//  1 Reset: RST=0 mid-run -> LED=0, BUSY=0, STEP_IDX=0, CFG_READY=1 immediately.
//  2 Write tab[0]={4'b0001,2}, tab[1]={4'b0010,1}, tab[2]={4'b0100,0}; START LEN=3
//    -> LED 0001 for 8 cyc, 0010 for 4, 0100 for 4, WRAP pulse, 0001 again.
//  3 In RUN assert CFG_VALID addr=1 pat=1111 -> CFG_READY=0, tab[1] unchanged.
//  4 START+STOP same cycle in IDLE -> stays IDLE; STOP at cycle 6 of RUN ->
//    next edge LED=0, BUSY=0; restart START -> begins at step 0, full duration.
//  5 START with LEN=0 and LEN=9 -> ignored, BUSY stays 0; LEN=1, dur0=3 ->
//    WRAP every 12 cycles, STEP_IDX constant 0.
//  6 START during RUN with LEN=2 (running LEN=3) -> sequence unaffected.

Source files
------------

// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared constants for the LED pattern sequencer
package led_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // 0.5 s base tick at 125 MHz
    localparam int DEFAULT_TICK_DIV = 62500000;

    localparam int DEFAULT_N_LED = 4;
    localparam int DEFAULT_DUR_W = 8;

endpackage

// File: rtl/led_tick_gen.sv
// rtl/led_tick_gen.sv - base-tick prescaler with enable and sync clear
module led_tick_gen
    import led_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i & ~clr_i & (cnt_q == CNT_MAX);

endmodule

// File: rtl/led_pattern_sequencer.sv
// rtl/led_pattern_sequencer.sv - steps LEDs through a programmable pattern/duration table
module led_pattern_sequencer
    import led_pkg::*;
#(
    parameter int N_LED    = DEFAULT_N_LED,
    parameter int N_STEP   = 8,
    parameter int DUR_W    = DEFAULT_DUR_W,
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        cfg_valid_i,
    output logic                        cfg_ready_o,
    input  logic [$clog2(N_STEP)-1:0]   cfg_addr_i,
    input  logic [N_LED-1:0]            cfg_pattern_i,
    input  logic [DUR_W-1:0]            cfg_dur_i,
    input  logic                        cmd_start_i,
    input  logic                        cmd_stop_i,
    input  logic [$clog2(N_STEP):0]     len_i,
    output logic [N_LED-1:0]            led_o,
    output logic                        busy_o,
    output logic [$clog2(N_STEP)-1:0]   step_idx_o,
    output logic                        wrap_o
);

    localparam int AW = $clog2(N_STEP);
    localparam logic [AW:0] LEN_MAX = (AW+1)'(N_STEP);
    localparam logic [DUR_W-1:0] DUR_ONE = DUR_W'(1);

    logic [N_LED-1:0] tab_pat_q [N_STEP];
    logic [DUR_W-1:0] tab_dur_q [N_STEP];

    logic [0:0]       state_q, state_d;
    logic [AW:0]      len_q, len_d;
    logic [AW-1:0]    idx_q, idx_d, nidx;
    logic [N_LED-1:0] led_q, led_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic             wrap_q, wrap_d;
    logic             run, tick, start_ok, last_step;

    assign run      = (state_q == ST_RUN);
    assign start_ok = cmd_start_i && (len_i != '0) && (len_i <= LEN_MAX);

    led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (run),
        .clr_i  (~run | cmd_stop_i),
        .tick_o (tick)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N_STEP; i++) begin
                tab_pat_q[i] <= '0;
                tab_dur_q[i] <= '0;
            end
        end else if (cfg_valid_i && !run) begin
            tab_pat_q[cfg_addr_i] <= cfg_pattern_i;
            tab_dur_q[cfg_addr_i] <= cfg_dur_i;
        end
    end

    assign last_step = ({1'b0, idx_q} == len_q - 1'b1);
    assign nidx      = last_step ? '0 : idx_q + 1'b1;

    // A duration of 0 is treated as 1 tick so every step is visible.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        led_d   = led_q;
        dur_d   = dur_q;
        wrap_d  = 1'b0;
        if (cmd_stop_i) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            led_d   = '0;
            dur_d   = '0;
        end else if (!run) begin
            if (start_ok) begin
                state_d = ST_RUN;
                len_d   = len_i;
                idx_d   = '0;
                led_d   = tab_pat_q[0];
                dur_d   = (tab_dur_q[0] == '0) ? DUR_ONE : tab_dur_q[0];
            end
        end else if (tick) begin
            if (dur_q > DUR_ONE) begin
                dur_d = dur_q - DUR_ONE;
            end else begin
                idx_d  = nidx;
                led_d  = tab_pat_q[nidx];
                dur_d  = (tab_dur_q[nidx] == '0) ? DUR_ONE : tab_dur_q[nidx];
                wrap_d = last_step;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            led_q   <= '0;
            dur_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            led_q   <= led_d;
            dur_q   <= dur_d;
            wrap_q  <= wrap_d;
        end
    end

    assign cfg_ready_o = ~run;
    assign busy_o      = run;
    assign led_o       = led_q;
    assign step_idx_o  = idx_q;
    assign wrap_o      = wrap_q;

endmodule
